// File: rtl/loader_wr_bridge.sv
// Loader-to-memory write bridge: a small FIFO absorbs loader write strobes and drains
// one entry per clock-enable slot, holding each memory write stable for CE_DIV cycles.
module loader_wr_bridge #(
  parameter int AW     = 22,
  parameter int DW     = 8,
  parameter int DEPTH  = 4,
  parameter int CE_DIV = 4
) (
  input  logic                       I_CLK,
  input  logic                       I_RESET_N,
  input  logic                       I_ENABLE,
  input  logic                       I_WR,
  input  logic [AW-1:0]              I_ADDR,
  input  logic [DW-1:0]              I_DATA,
  output logic [$clog2(CE_DIV)-1:0]  O_CE_PHASE,
  output logic                       O_CE,
  output logic                       O_MEM_WE,
  output logic [AW-1:0]              O_MEM_ADDR,
  output logic [DW-1:0]              O_MEM_DATA,
  output logic [$clog2(DEPTH):0]     O_COUNT,
  output logic                       O_FULL,
  output logic                       O_EMPTY,
  output logic                       O_OVERFLOW
);

  localparam int PW   = $clog2(CE_DIV);
  localparam int PTRW = $clog2(DEPTH);
  localparam int CW   = PTRW + 1;
  localparam logic [PW-1:0] PHASE_LAST = PW'(CE_DIV - 1);
  localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } entry_t;

  logic [PW-1:0]   phase_q;
  logic [PTRW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTRW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            ovf_q, ovf_d;
  logic            we_q, we_d;
  entry_t          out_q, out_d;
  entry_t          mem_q [DEPTH];

  logic slot, full, empty, pop, push;

  // A pop only sees entries counted before this edge, so a same-edge push never bypasses.
  assign slot  = (phase_q == PHASE_LAST);
  assign full  = (count_q == COUNT_FULL);
  assign empty = (count_q == '0);
  assign pop   = slot && I_ENABLE && !empty;
  assign push  = I_WR && I_ENABLE && (!full || pop);

  // FIFO bookkeeping; a low enable flushes everything including the sticky overflow.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (!I_ENABLE) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTRW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTRW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
      if (I_WR && full && !pop) ovf_d = 1'b1;
    end
  end

  // Memory-side request only moves at slot edges; address/data hold when idle.
  always_comb begin
    we_d  = we_q;
    out_d = out_q;
    if (slot) begin
      we_d = pop;
      if (pop) out_d = mem_q[rd_ptr_q];
    end
  end

  always_ff @(posedge I_CLK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      phase_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      we_q     <= 1'b0;
      out_q    <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      phase_q  <= phase_q + PW'(1);
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      we_q     <= we_d;
      out_q    <= out_d;
    end
  end

  // NOTE: storage is not reset; count and pointers alone decide which entries are valid.
  always_ff @(posedge I_CLK) begin
    if (push) mem_q[wr_ptr_q] <= entry_t'{addr: I_ADDR, data: I_DATA};
  end

  assign O_CE_PHASE = phase_q;
  assign O_CE       = slot;
  assign O_MEM_WE   = we_q;
  assign O_MEM_ADDR = out_q.addr;
  assign O_MEM_DATA = out_q.data;
  assign O_COUNT    = count_q;
  assign O_FULL     = full;
  assign O_EMPTY    = empty;
  assign O_OVERFLOW = ovf_q;

endmodule

// File: tb/tb_loader_wr_bridge.sv
// Directed bench for loader_wr_bridge: a cycle-by-cycle vector table of expected outputs
// plus hand-written sequences for power-up phase wrap and reset mid-period.
module tb_loader_wr_bridge;
  localparam int AW     = 22;
  localparam int DW     = 8;
  localparam int DEPTH  = 4;
  localparam int CE_DIV = 4;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          en    = 1'b0;
  logic          wr    = 1'b0;
  logic [AW-1:0] addr  = '0;
  logic [DW-1:0] data  = '0;

  logic [1:0]    ce_phase;
  logic          ce;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic [2:0]    count;
  logic          full;
  logic          empty;
  logic          overflow;

  loader_wr_bridge #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .CE_DIV(CE_DIV)) dut (
    .I_CLK      (clk),
    .I_RESET_N  (rst_n),
    .I_ENABLE   (en),
    .I_WR       (wr),
    .I_ADDR     (addr),
    .I_DATA     (data),
    .O_CE_PHASE (ce_phase),
    .O_CE       (ce),
    .O_MEM_WE   (mem_we),
    .O_MEM_ADDR (mem_addr),
    .O_MEM_DATA (mem_data),
    .O_COUNT    (count),
    .O_FULL     (full),
    .O_EMPTY    (empty),
    .O_OVERFLOW (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            en;
    bit            wr;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int            ph;
    bit            we;
    logic [AW-1:0] ma;
    logic [DW-1:0] md;
    int            cnt;
    bit            ovf;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input int ph, input bit we,
                               input logic [AW-1:0] ma, input logic [DW-1:0] md,
                               input int cnt, input bit ovf);
    check({tag, " phase"},    64'(ce_phase), 64'(ph));
    check({tag, " ce"},       64'(ce),       64'(ph == CE_DIV - 1));
    check({tag, " mem_we"},   64'(mem_we),   64'(we));
    check({tag, " mem_addr"}, 64'(mem_addr), 64'(ma));
    check({tag, " mem_data"}, 64'(mem_data), 64'(md));
    check({tag, " count"},    64'(count),    64'(cnt));
    check({tag, " full"},     64'(full),     64'(cnt == DEPTH));
    check({tag, " empty"},    64'(empty),    64'(cnt == 0));
    check({tag, " overflow"}, 64'(overflow), 64'(ovf));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void add(input bit e, input bit w, input logic [AW-1:0] a,
                              input logic [DW-1:0] d, input int ph, input bit we,
                              input logic [AW-1:0] ma, input logic [DW-1:0] md,
                              input int cnt, input bit ovf);
    vec_t v;
    v.en = e; v.wr = w; v.a = a; v.d = d;
    v.ph = ph; v.we = we; v.ma = ma; v.md = md; v.cnt = cnt; v.ovf = ovf;
    vecs.push_back(v);
  endfunction

  // One full presentation period with no loader activity: phases 0..3 hold the same request.
  function automatic void grp(input bit we, input logic [AW-1:0] ma,
                              input logic [DW-1:0] md, input int cnt, input bit ovf);
    for (int p = 0; p < CE_DIV; p++) add(1, 0, '0, '0, p, we, ma, md, cnt, ovf);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state while held.
    #2;
    check_outputs("reset", 0, 0, '0, '0, 0, 0);

    // Release between edges; phase is 0 until the first edge, then free-runs.
    #10;
    en    = 1'b1;
    rst_n = 1'b1;
    #1;
    for (int c = 0; c < 16; c++) begin
      check($sformatf("wrap c%0d phase", c), 64'(ce_phase), 64'(c % 4));
      check($sformatf("wrap c%0d ce", c),    64'(ce),       64'(c % 4 == 3));
      tick();
    end
    tick();  // now at phase 1

    // Single write issued at phase 1.
    add(1, 1, 'h10, 'hA5, 2, 0, '0, '0, 1, 0);
    add(1, 0, '0,   '0,   3, 0, '0, '0, 1, 0);
    grp(1, 'h10, 'hA5, 0, 0);
    add(1, 0, '0, '0, 0, 0, 'h10, 'hA5, 0, 0);

    // Burst of six writes from phase 0: the sixth is dropped.
    add(1, 1, 'h101, 'h01, 1, 0, 'h10,  'hA5, 1, 0);
    add(1, 1, 'h102, 'h02, 2, 0, 'h10,  'hA5, 2, 0);
    add(1, 1, 'h103, 'h03, 3, 0, 'h10,  'hA5, 3, 0);
    add(1, 1, 'h104, 'h04, 0, 1, 'h101, 'h01, 3, 0);
    add(1, 1, 'h105, 'h05, 1, 1, 'h101, 'h01, 4, 0);
    add(1, 1, 'h106, 'h06, 2, 1, 'h101, 'h01, 4, 1);
    add(1, 0, '0,    '0,   3, 1, 'h101, 'h01, 4, 1);
    grp(1, 'h102, 'h02, 3, 1);
    grp(1, 'h103, 'h03, 2, 1);
    grp(1, 'h104, 'h04, 1, 1);
    grp(1, 'h105, 'h05, 0, 1);

    // Flush with three queued and one presented; a write during the flush is ignored.
    add(1, 1, 'h301, 'h31, 0, 0, 'h105, 'h05, 1, 1);
    add(1, 1, 'h302, 'h32, 1, 0, 'h105, 'h05, 2, 1);
    add(1, 1, 'h303, 'h33, 2, 0, 'h105, 'h05, 3, 1);
    add(1, 1, 'h304, 'h34, 3, 0, 'h105, 'h05, 4, 1);
    add(1, 0, '0,    '0,   0, 1, 'h301, 'h31, 3, 1);
    add(0, 1, 'h3FF, 'hFF, 1, 1, 'h301, 'h31, 0, 0);
    add(1, 0, '0,    '0,   2, 1, 'h301, 'h31, 0, 0);
    add(1, 0, '0,    '0,   3, 1, 'h301, 'h31, 0, 0);
    grp(0, 'h301, 'h31, 0, 0);
    grp(0, 'h301, 'h31, 0, 0);

    // Fill to full, then write on a slot edge: accepted, count holds at 4, no overflow.
    add(1, 1, 'h201, 'h11, 0, 0, 'h301, 'h31, 1, 0);
    add(1, 1, 'h202, 'h12, 1, 0, 'h301, 'h31, 2, 0);
    add(1, 1, 'h203, 'h13, 2, 0, 'h301, 'h31, 3, 0);
    add(1, 1, 'h204, 'h14, 3, 0, 'h301, 'h31, 4, 0);
    add(1, 1, 'h205, 'h15, 0, 1, 'h201, 'h11, 4, 0);
    add(1, 0, '0,    '0,   1, 1, 'h201, 'h11, 4, 0);
    add(1, 0, '0,    '0,   2, 1, 'h201, 'h11, 4, 0);
    add(1, 0, '0,    '0,   3, 1, 'h201, 'h11, 4, 0);
    grp(1, 'h202, 'h12, 3, 0);
    grp(1, 'h203, 'h13, 2, 0);
    grp(1, 'h204, 'h14, 1, 0);
    grp(1, 'h205, 'h15, 0, 0);
    grp(0, 'h205, 'h15, 0, 0);

    foreach (vecs[i]) begin
      en   = vecs[i].en;
      wr   = vecs[i].wr;
      addr = vecs[i].a;
      data = vecs[i].d;
      tick();
      check_outputs($sformatf("row%0d", i), vecs[i].ph, vecs[i].we, vecs[i].ma,
                    vecs[i].md, vecs[i].cnt, vecs[i].ovf);
    end

    // Reset asserted at phase 2 while a write is presented and another is queued.
    en = 1'b1; wr = 1'b1; addr = 'h3AB; data = 'h5C;
    tick();
    addr = 'h3AC; data = 'h5D;
    tick();
    wr = 1'b0; addr = '0; data = '0;
    for (int k = 0; k < 5; k++) tick();
    check_outputs("pre_rst", 2, 1, 'h3AB, 'h5C, 1, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs("rst_async", 0, 0, '0, '0, 0, 0);
    tick();
    check_outputs("rst_held", 0, 0, '0, '0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_outputs("rst_rel", 0, 0, '0, '0, 0, 0);
    for (int k = 1; k <= 8; k++) begin
      tick();
      check_outputs($sformatf("post_rst%0d", k), k % 4, 0, '0, '0, 0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
